// File: rtl/light_organ.sv
// Light organ: per-channel envelopes drive a PWM-dimmed user LED and a serial
// shift/latch frame for an external lamp driver. Define LIGHT_ORGAN_GAMMA_EN for squared LED brightness.
module light_organ #(
  parameter int CHANNELS    = 4,
  parameter int PWM_BITS    = 8,
  parameter int DECAY_SHIFT = 4,
  parameter int SHIFT_DIV   = 8,
  parameter int THRESH      = 128
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         decay_tick,
  input  logic [CHANNELS-1:0]          chan_trig,
  input  logic [CHANNELS*PWM_BITS-1:0] chan_level,
  input  logic [1:0]                   mode,
  output logic                         led_user,
  output logic                         ser_clk,
  output logic                         ser_dat,
  output logic                         ser_latch,
  output logic                         busy
);

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } ser_state_e;

  logic [PWM_BITS-1:0] env_q [CHANNELS];
  logic [PWM_BITS-1:0] env_d [CHANNELS];
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] max_env;
  logic [PWM_BITS-1:0] bright;
  logic                led_q, led_d;

  ser_state_e          state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHANNELS-1:0] bits_q, bits_d;
  logic [CHANNELS-1:0] lit;
  logic                div_last;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      env_d[i] = env_q[i];
      if (chan_trig[i]) begin
        env_d[i] = chan_level[i*PWM_BITS +: PWM_BITS];
      end else if (decay_tick && env_q[i] != '0) begin
        // Decay is proportional, but never less than one step so envelopes reach zero.
        env_d[i] = env_q[i] - (((env_q[i] >> DECAY_SHIFT) == '0) ? PWM_BITS'(1)
                                                                  : (env_q[i] >> DECAY_SHIFT));
      end
    end
  end

  always_comb begin
    max_env = '0;
    lit     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (env_q[i] > max_env) max_env = env_q[i];
      lit[i] = int'(env_q[i]) >= THRESH;
    end
  end

`ifdef LIGHT_ORGAN_GAMMA_EN
  logic [2*PWM_BITS-1:0] max_sq;
  always_comb begin
    max_sq = {{PWM_BITS{1'b0}}, max_env} * {{PWM_BITS{1'b0}}, max_env};
    bright = max_sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  always_comb bright = max_env;
`endif

  always_comb led_d = (mode == 2'd0) && (bright > pwm_cnt_q);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    bits_d   = bits_q;
    div_last = (div_q == DIV_W'(SHIFT_DIV - 1));
    if (mode != 2'd1) begin
      // Leaving serial mode abandons the frame outright; no latch pulse is issued.
      state_d = IDLE;
      div_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pwm_cnt_q == '0) begin
            state_d = SHIFT_LO;
            div_d   = '0;
            idx_d   = IDX_W'(CHANNELS - 1);
            bits_d  = lit;
          end
        end
        SHIFT_LO: begin
          div_d = div_q + DIV_W'(1);
          if (div_last) begin
            state_d = SHIFT_HI;
            div_d   = '0;
          end
        end
        SHIFT_HI: begin
          div_d = div_q + DIV_W'(1);
          if (div_last) begin
            div_d = '0;
            if (idx_q == '0) begin
              state_d = LATCH;
            end else begin
              state_d = SHIFT_LO;
              idx_d   = idx_q - IDX_W'(1);
            end
          end
        end
        LATCH: begin
          div_d = div_q + DIV_W'(1);
          if (div_last) begin
            state_d = IDLE;
            div_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the envelope array is a handful of flops, not a RAM, so it is reset with everything else.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) env_q[i] <= '0;
      pwm_cnt_q <= '0;
      led_q     <= 1'b0;
      state_q   <= IDLE;
      div_q     <= '0;
      idx_q     <= '0;
      bits_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int i = 0; i < CHANNELS; i++) env_q[i] <= env_d[i];
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_q     <= led_d;
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      bits_q    <= bits_d;
    end
  end

  // Serial outputs decode straight from registered state, so reset clears them asynchronously.
  assign led_user  = led_q;
  assign busy      = (state_q != IDLE);
  assign ser_clk   = (state_q == SHIFT_HI);
  assign ser_dat   = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && bits_q[idx_q];
  assign ser_latch = (state_q == LATCH);

endmodule

// File: tb/tb_light_organ.sv
// Self-checking bench for light_organ: randomized stimulus against a cycle-level
// behavioural model of envelopes, PWM compare and serial frame timing.
module tb_light_organ;

  localparam int CH    = 4;
  localparam int PB    = 8;
  localparam int DS    = 4;
  localparam int SD    = 2;
  localparam int TH    = 128;
  localparam int FRAME = CH * 2 * SD + SD;
  localparam int TRACE = FRAME + 12;

  logic               clk_sys    = 1'b0;
  logic               reset_n    = 1'b0;
  logic               decay_tick = 1'b0;
  logic [CH-1:0]      chan_trig  = '0;
  logic [CH*PB-1:0]   chan_level = '0;
  logic [1:0]         mode       = 2'd2;
  logic               led_user, ser_clk, ser_dat, ser_latch, busy;

  int errors = 0;
  int checks = 0;

  int m_env [CH];
  int m_pwm;
  bit exp_led;

  light_organ #(
    .CHANNELS(CH), .PWM_BITS(PB), .DECAY_SHIFT(DS), .SHIFT_DIV(SD), .THRESH(TH)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .decay_tick(decay_tick),
    .chan_trig (chan_trig),
    .chan_level(chan_level),
    .mode      (mode),
    .led_user  (led_user),
    .ser_clk   (ser_clk),
    .ser_dat   (ser_dat),
    .ser_latch (ser_latch),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int bright(int m);
`ifdef LIGHT_ORGAN_GAMMA_EN
    return (m * m) / (1 << PB);
`else
    return m;
`endif
  endfunction

  function automatic int model_max();
    int m = 0;
    for (int i = 0; i < CH; i++) if (m_env[i] > m) m = m_env[i];
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CH; i++) m_env[i] = 0;
    m_pwm   = 0;
    exp_led = 1'b0;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic cycle();
    int nxt [CH];
    int step;
    exp_led = (mode == 2'd0) && (bright(model_max()) > m_pwm);
    for (int i = 0; i < CH; i++) begin
      nxt[i] = m_env[i];
      if (chan_trig[i]) begin
        nxt[i] = int'(chan_level[i*PB +: PB]);
      end else if (decay_tick && m_env[i] > 0) begin
        step = m_env[i] / (1 << DS);
        if (step < 1) step = 1;
        nxt[i] = m_env[i] - step;
      end
    end
    @(posedge clk_sys);
    for (int i = 0; i < CH; i++) m_env[i] = nxt[i];
    m_pwm = (m_pwm + 1) % (1 << PB);
    #1;
  endtask

  task automatic load_levels(input logic [CH*PB-1:0] levels);
    chan_level = levels;
    chan_trig  = '1;
    cycle();
    chan_trig  = '0;
  endtask

  task automatic measure_duty(output int n);
    n = 0;
    for (int k = 0; k < (1 << PB); k++) begin
      cycle();
      if (led_user) n++;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      cycle();
      if (busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({led_user, ser_clk, ser_dat, ser_latch, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {led_user, ser_clk, ser_dat, ser_latch, busy});
    end
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_pwm();
    int n;
    mode = 2'd0;
    load_levels({8'd0, 8'd0, 8'd0, 8'd200});
    for (int p = 0; p < 3; p++) begin
      n = 0;
      for (int k = 0; k < (1 << PB); k++) begin
        cycle();
        if (led_user) n++;
        checks++;
        if (led_user !== exp_led || {ser_clk, ser_dat, ser_latch, busy} !== 4'b0) begin
          errors++;
          $display("FAIL pwm_cycle p%0d k%0d: led=%b ser=%b expected led=%b ser=0000",
                   p, k, led_user, {ser_clk, ser_dat, ser_latch, busy}, exp_led);
        end
      end
      checks++;
      if (n != bright(200)) begin
        errors++;
        $display("FAIL pwm_duty period %0d: got %0d expected %0d", p, n, bright(200));
      end
    end
  endtask

  task automatic test_decay();
    int lvl [5] = '{200, 10, 1, 0, 150};
    int exp [5] = '{188, 9, 0, 0, 77};
    int n;
    mode = 2'd0;
    for (int c = 0; c < 5; c++) begin
      load_levels({24'd0, 8'(lvl[c])});
      decay_tick = 1'b1;
      if (c == 4) begin
        chan_level = {24'd0, 8'd77};
        chan_trig  = 4'b0001;
      end
      cycle();
      decay_tick = 1'b0;
      chan_trig  = '0;
      measure_duty(n);
      checks++;
      if (n != bright(exp[c])) begin
        errors++;
        $display("FAIL decay case %0d (level %0d): duty %0d expected %0d", c, lvl[c], n, bright(exp[c]));
      end
    end
  endtask

  task automatic test_serial_frame();
    bit ok;
    bit exp_bits [CH];
    logic [3:0] trace [TRACE];
    logic [3:0] want;
    int slot, ph;
    mode = 2'd2;
    load_levels({8'd200, 8'd0, 8'd255, 8'd50});
    mode = 2'd1;
    for (int j = 0; j < CH; j++) exp_bits[j] = (m_env[CH-1-j] >= TH);
    wait_busy(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL serial_start: busy never rose within 600 cycles");
      return;
    end
    checks++;
    if (m_pwm != 1) begin
      errors++;
      $display("FAIL serial_start_phase: frame began with pwm phase %0d expected 1", m_pwm);
    end
    trace[0] = {busy, ser_clk, ser_dat, ser_latch};
    for (int k = 1; k < TRACE; k++) begin
      cycle();
      trace[k] = {busy, ser_clk, ser_dat, ser_latch};
      checks++;
      if (led_user !== 1'b0) begin
        errors++;
        $display("FAIL serial_led k%0d: led=%b expected 0", k, led_user);
      end
    end
    for (int k = 0; k < TRACE; k++) begin
      slot = k / (2 * SD);
      ph   = k % (2 * SD);
      if (k < CH * 2 * SD)  want = {1'b1, ph >= SD, exp_bits[slot], 1'b0};
      else if (k < FRAME)   want = 4'b1001;
      else                  want = 4'b0000;
      checks++;
      if (trace[k] !== want) begin
        errors++;
        $display("FAIL serial_frame k%0d: busy/clk/dat/latch=%b expected %b", k, trace[k], want);
      end
    end
  endtask

  task automatic test_mode_abort();
    bit ok;
    mode = 2'd1;
    wait_busy(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_start: busy never rose within 600 cycles");
      return;
    end
    repeat (5) cycle();
    mode = 2'd2;
    cycle();
    checks++;
    if ({ser_clk, ser_dat, ser_latch, busy} !== 4'b0) begin
      errors++;
      $display("FAIL abort_idle: clk/dat/latch/busy=%b expected 0000", {ser_clk, ser_dat, ser_latch, busy});
    end
    for (int k = 0; k < 40; k++) begin
      cycle();
      checks++;
      if (ser_latch !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_latch k%0d: latch=%b busy=%b expected 0 0", k, ser_latch, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int k;
    mode = 2'd1;
    load_levels({8'd255, 8'd255, 8'd255, 8'd255});
    wait_busy(ok);
    k = 0;
    while (ok && !ser_clk && k < 20) begin
      cycle();
      k++;
    end
    checks++;
    if (!ok || !ser_clk) begin
      errors++;
      $display("FAIL async_setup: never reached shift-high (busy=%b clk=%b)", busy, ser_clk);
      return;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({led_user, ser_clk, ser_dat, ser_latch, busy} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: outputs %b expected 00000 before any edge",
               {led_user, ser_clk, ser_dat, ser_latch, busy});
    end
    mode = 2'd2;
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_mode_off();
    mode = 2'd2;
    for (int k = 0; k < 1000; k++) begin
      chan_trig  = CH'($urandom_range(0, (1 << CH) - 1));
      chan_level = CH*PB'($urandom);
      decay_tick = ($urandom_range(0, 3) == 0);
      cycle();
      checks++;
      if ({led_user, ser_clk, ser_dat, ser_latch, busy} !== 5'b0) begin
        errors++;
        $display("FAIL mode_off k%0d: outputs %b expected 00000", k, {led_user, ser_clk, ser_dat, ser_latch, busy});
      end
    end
    chan_trig  = '0;
    decay_tick = 1'b0;
  endtask

  task automatic test_gamma_point();
    int n;
    int want;
`ifdef LIGHT_ORGAN_GAMMA_EN
    want = 64;
`else
    want = 128;
`endif
    mode = 2'd0;
    load_levels({24'd0, 8'd128});
    measure_duty(n);
    checks++;
    if (n != want) begin
      errors++;
      $display("FAIL gamma_point: duty %0d expected %0d", n, want);
    end
  endtask

  task automatic test_random_pwm();
    mode = 2'd0;
    for (int k = 0; k < 3000; k++) begin
      chan_trig = '0;
      for (int i = 0; i < CH; i++) chan_trig[i] = ($urandom_range(0, 15) == 0);
      chan_level = CH*PB'($urandom);
      decay_tick = ($urandom_range(0, 2) == 0);
      cycle();
      checks++;
      if (led_user !== exp_led || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_pwm k%0d: led=%b busy=%b expected led=%b busy=0", k, led_user, busy, exp_led);
      end
    end
    chan_trig  = '0;
    decay_tick = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_pwm();
    test_decay();
    test_serial_frame();
    test_mode_abort();
    test_async_reset();
    test_mode_off();
    test_gamma_point();
    test_random_pwm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
